seq_serializer: RTL
===================

Name: seq_serializer

Overview:
- Upstream feeder for the Moore sequence detector. Accepts parallel words over a valid/ready handshake and emits them as a 1-bit serial stream, MSB first.
- o_seq drives the detector's i_seq input directly. o_seq_vld marks the cycles in which the bit is a real data bit.
- Output timing is fully registered, so the detector samples a stable bit on every clock edge.

Parameters:
- DW, 8, width of parallel input word (≥2).
- IDLE_BIT, 1'b0, value driven on o_seq when no word is being shifted.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_data  input  DW  parallel word; sampled when i_vld & o_rdy.
- i_vld  input  1  word valid.
- o_rdy  output  1  serializer can accept a word this cycle.
- i_en  input  1  bit-strobe; the shift advances only on cycles with i_en=1.
- o_seq  output  1  serial bit (registered).
- o_seq_vld  output  1  o_seq holds a data bit (registered).
- o_busy  output  1  a word is in flight or buffered.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, shift reg=0, bit counter=0, o_seq=IDLE_BIT, o_seq_vld=0, o_busy=0, o_rdy=0 while i_rst is high.
- FSM states: IDLE, SHIFT.
- IDLE:
  - o_rdy=1.
  - On accept (i_vld & o_rdy at edge N): load i_data and set cnt=DW-1.
  - At edge N, o_seq<=i_data[DW-1] and o_seq_vld<=1, so the bit is visible in the cycle after N. Go to SHIFT.
- SHIFT:
  - o_rdy=0.
  - On an edge with i_en=1 and cnt≠0: shift left, o_seq<=next bit, cnt<=cnt-1.
  - On an edge with i_en=1 and cnt==0: the word is done; o_seq<=IDLE_BIT, o_seq_vld<=0, go to IDLE.
  - i_en=0: o_seq, o_seq_vld and cnt all hold.
- Bit timing: each data bit is held for exactly the i_en=1 cycles that consume it. The first bit appears independent of i_en.
- Minimum gap: one IDLE_BIT cycle between consecutive words.
- o_busy = (state==SHIFT), registered.
- i_vld while o_rdy=0: ignored. The upstream must hold i_data/i_vld until the handshake occurs.
- i_data changing after acceptance: no effect.
- Reset mid-word: aborts immediately (async); outputs return to reset values; the partial word is discarded.
- Counter width: $clog2(DW); no wrap beyond DW-1.

Optional Feature:
- Macro SEQ_SER_PRELOAD_EN.
- Defined:
  - Adds a one-entry holding register (hold_vld, hold_data). o_rdy = ~hold_vld, in either state.
  - A word accepted during SHIFT goes to the holding register.
  - On the final-bit edge (i_en=1, cnt==0) with hold_vld=1: load hold_data directly, o_seq<=its MSB, o_seq_vld stays 1, state stays SHIFT, hold_vld<=0. This gives gapless back-to-back words.
  - Simultaneous final-bit and new accept with hold empty: the new word is loaded straight into the shifter.
  - o_busy = SHIFT | hold_vld.
  - Reset clears hold_vld.
- Undefined: behaviour exactly as above, with a one-cycle gap between words.

Decomposition:
- Shared package seq_pkg:
  - State encoding localparams S_IDLE=1'b0, S_SHIFT=1'b1.
  - Default DW.
  - The detector's target pattern constant, so bench stimulus and detector agree.
- One natural sub-module, seq_shift_reg: loadable DW-bit left shifter with enable, exposing MSB. The FSM and counter stay in the top.

Test Plan:
- Reset: assert i_rst mid-cycle with i_clk idle → o_seq=0, o_seq_vld=0, o_busy=0 immediately; after release, o_rdy=1.
- Single word: DW=8, i_en=1, send 8'hB4 → next 8 cycles o_seq=1,0,1,1,0,1,0,0 with o_seq_vld=1; then o_seq=IDLE_BIT, o_rdy=1.
- Stall: send 8'hA5 with i_en toggling 1,0,1,0… → each bit held 2 cycles; total 16 cycles of o_seq_vld=1; sequence 1,0,1,0,0,1,0,1 unchanged.
- Back-pressure: hold i_vld=1 with 8'h0F then 8'hF0 → second accept only when o_rdy=1.
  - Undefined macro: exactly one o_seq_vld=0 cycle between words.
  - SEQ_SER_PRELOAD_EN: zero gap, 16 contiguous valid bits 0000111111110000.
- Abort: reset at bit 3 of 8'hFF, then send 8'h01 → stream after reset is 0000_0001 only; no residue of 8'hFF.
- End-to-end: drive the detector with o_seq, feed words containing its pattern at known offsets → detector o_out asserts the expected cycle after each pattern's final bit, and never otherwise.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer / Moore sequence detector pair.
//   S_IDLE / S_SHIFT : serializer FSM state encoding
//   SEQ_DW           : default parallel word width
//   SEQ_PATTERN      : bit pattern the downstream detector looks for, kept
//                      here so the stimulus and the detector cannot drift apart
package seq_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    localparam int SEQ_DW = 8;

    localparam int                   SEQ_PAT_W   = 4;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bus of the serializer.
//   master : upstream side (drives i_data, i_vld, i_en; sees rdy / serial bit)
//   slave  : serializer side
interface seq_serializer_if
    import seq_pkg::*;
#(
    parameter int DW = SEQ_DW
);
    logic [DW-1:0] i_data;
    logic          i_vld;
    logic          o_rdy;
    logic          i_en;
    logic          o_seq;
    logic          o_seq_vld;
    logic          o_busy;

    modport master (
        output i_data, i_vld, i_en,
        input  o_rdy, o_seq, o_seq_vld, o_busy
    );

    modport slave (
        input  i_data, i_vld, i_en,
        output o_rdy, o_seq, o_seq_vld, o_busy
    );
endinterface

// File: rtl/seq_serializer_shift_reg.sv
// seq_shift_reg: loadable DW-bit left shifter with enable.
//   i_clk, i_rst : clock, async active-high reset (clears the register)
//   i_load       : load i_din (has priority over i_shift)
//   i_shift      : shift left by one, zero fill
//   o_msb        : current MSB
module seq_shift_reg #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [DW-1:0] i_din,
    output logic          o_msb
);
    logic [DW-1:0] sreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        sreg <= '0;
        else if (i_load)  sreg <= i_din;
        else if (i_shift) sreg <= {sreg[DW-2:0], 1'b0};
    end

    assign o_msb = sreg[DW-1];
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: parallel word -> MSB-first serial stream for the sequence
// detector. o_seq / o_seq_vld / o_busy are registered.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : i_data/i_vld/o_rdy word handshake, i_en bit strobe,
//                  o_seq serial bit, o_seq_vld data-bit flag, o_busy
// Optional: define SEQ_SER_PRELOAD_EN to add a one-word holding register
// that makes consecutive words gapless.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   DW       = SEQ_DW,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    seq_serializer_if.slave  bus
);
    localparam int CW = $clog2(DW);

    logic          state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          seq_q, seq_vld_q, busy_q;
    logic          rdy, accept, last, load, shift;
    logic [DW-1:0] load_data;
    logic          sh_msb;

`ifdef SEQ_SER_PRELOAD_EN
    logic          hold_vld_q, hold_vld_d, hold_wr;
    logic [DW-1:0] hold_data_q;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            default: if (last && !load) state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs / datapath controls ----------------
    always_comb begin
        load      = 1'b0;
        load_data = bus.i_data;
`ifdef SEQ_SER_PRELOAD_EN
        hold_wr   = 1'b0;
        rdy       = ~hold_vld_q;
`else
        rdy       = (state_q == S_IDLE);
`endif
        if (i_rst) rdy = 1'b0;
        accept = bus.i_vld & rdy;
        last   = (state_q == S_SHIFT) & bus.i_en & (cnt_q == '0);
        shift  = (state_q == S_SHIFT) & bus.i_en & (cnt_q != '0);

        if (state_q == S_IDLE) begin
            load = accept;
        end
`ifdef SEQ_SER_PRELOAD_EN
        else if (last) begin
            // Final bit: chain straight into the buffered word, or into a
            // word arriving on this very edge if the buffer is empty.
            if (hold_vld_q) begin
                load      = 1'b1;
                load_data = hold_data_q;
            end else begin
                load = accept;
            end
        end else begin
            hold_wr = accept;
        end
`endif
    end

`ifdef SEQ_SER_PRELOAD_EN
    always_comb begin
        hold_vld_d = hold_vld_q;
        if (hold_wr)                 hold_vld_d = 1'b1;
        else if (last && hold_vld_q) hold_vld_d = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            if (hold_wr) hold_data_q <= bus.i_data;
        end
    end
`endif

    // The MSB goes straight to o_seq on load, so the shifter holds only the
    // remaining bits; its MSB is then always the next bit to emit.
    seq_shift_reg #(.DW(DW)) u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_shift (shift),
        .i_din   ({load_data[DW-2:0], 1'b0}),
        .o_msb   (sh_msb)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= '0;
            seq_q     <= IDLE_BIT;
            seq_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
`ifdef SEQ_SER_PRELOAD_EN
            busy_q <= (state_d == S_SHIFT) | hold_vld_d;
`else
            busy_q <= (state_d == S_SHIFT);
`endif
            if (load) begin
                seq_q     <= load_data[DW-1];
                seq_vld_q <= 1'b1;
                cnt_q     <= CW'(DW-1);
            end else if (shift) begin
                seq_q <= sh_msb;
                cnt_q <= cnt_q - CW'(1);
            end else if (last) begin
                seq_q     <= IDLE_BIT;
                seq_vld_q <= 1'b0;
            end
        end
    end

    assign bus.o_rdy     = rdy;
    assign bus.o_seq     = seq_q;
    assign bus.o_seq_vld = seq_vld_q;
    assign bus.o_busy    = busy_q;
endmodule
